medidor_de_frequencia: RTL and testbench

Frequency meter that recovers the tuning word of a phase-accumulator square wave. It samples an asynchronous square-wave input, counts its rising edges over a fixed gate window of 2^(WIDTH+1) clock cycles, and reports both the raw edge count and the estimated tuning word. It sits on the receive side of the arbitrary-frequency generator: a generator driven with word D produces D+1 rising edges per window (±1 from phase alignment), so a loopback closes generator→meter.

---
 rtl/medidor_de_frequencia.sv | 134 +++++++++++++
 tb/tb_medidor_de_frequencia.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/medidor_de_frequencia.sv
// medidor_de_frequencia: counts synchronized rising edges of sig_in over a
// gate window of 2^(WIDTH+1) clocks and reports the count plus the tuning
// word (count - 1) that a phase-accumulator generator would have used.
module medidor_de_frequencia #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sig_in,
  output logic [WIDTH:0]   edges,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             no_signal,
  output logic             busy
);

  localparam logic [WIDTH:0] GATE_LAST = '1;

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t state;
  state_t state_next;

  logic sig_m;
  logic sig_s;
  logic sig_d;
  logic rise;

  logic [WIDTH:0]   gate_cnt;
  logic [WIDTH:0]   edge_cnt;
  logic [WIDTH:0]   result_cnt;
  logic [WIDTH:0]   pending;
  logic [WIDTH-1:0] pending_word;
  logic             final_cycle;
  logic             done;

  assign rise = sig_s & ~sig_d;
  assign busy = (state == MEASURE);

  // Two-flop synchronizer plus one delay stage for rising-edge detection; runs regardless of enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_m <= 1'b0;
      sig_s <= 1'b0;
      sig_d <= 1'b0;
    end else begin
      sig_m <= sig_in;
      sig_s <= sig_m;
      sig_d <= sig_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: enable keeps us measuring (back-to-back windows), dropping it returns to idle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable)  state_next = MEASURE;
      MEASURE: if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Detect the last gate cycle and fold in an edge that lands exactly on it.
  always_comb begin
    final_cycle = 1'b0;
    result_cnt  = edge_cnt + {{WIDTH{1'b0}}, rise};
    if (state == MEASURE && gate_cnt == GATE_LAST) begin
      final_cycle = 1'b1;
    end
  end

  // Gate and edge counters: advance while measuring, clear on window end, abort or idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
    end else if (state == MEASURE && enable && !final_cycle) begin
      gate_cnt <= gate_cnt + 1'b1;
      edge_cnt <= edge_cnt + {{WIDTH{1'b0}}, rise};
    end else begin
      gate_cnt <= '0;
      edge_cnt <= '0;
    end
  end

  // Capture the finished window's count; results are published one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done    <= 1'b0;
      pending <= '0;
    end else begin
      done <= final_cycle;
      if (final_cycle) begin
        pending <= result_cnt;
      end
    end
  end

  // Tuning word is count minus one; the low WIDTH bits suffice since count never exceeds 2^WIDTH.
  always_comb begin
    pending_word = '0;
    if (pending != '0) begin
      pending_word = pending[WIDTH-1:0] - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Result registers and the one-cycle valid pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid     <= 1'b0;
      edges     <= '0;
      data_out  <= '0;
      no_signal <= 1'b0;
    end else begin
      valid <= done;
      if (done) begin
        edges     <= pending;
        data_out  <= pending_word;
        no_signal <= (pending == '0);
      end
    end
  end

endmodule

// File: tb/tb_medidor_de_frequencia.sv
// Testbench for medidor_de_frequencia (WIDTH=4, 32-cycle window): directed
// stimulus patterns, a window-counting reference model, and literal checks.
module tb_medidor_de_frequencia;

  localparam int WIDTH = 4;
  localparam int WIN   = 1 << (WIDTH + 1);
  localparam int HMAX  = 8192;

  logic             clk;
  logic             rst;
  logic             enable;
  logic             sig_in;
  logic [WIDTH:0]   edges;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             no_signal;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  int mode   = 0;
  int period = 8;
  int phase  = 0;
  logic [WIDTH:0] acc = '0;

  bit cmp_en = 0;

  medidor_de_frequencia #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .sig_in    (sig_in),
    .edges     (edges),
    .data_out  (data_out),
    .valid     (valid),
    .no_signal (no_signal),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: sampled input history and window bookkeeping.
  int cyc = 0;
  bit s_hist [0:HMAX-1];
  bit in_win = 0;
  int win_start = 0;
  bit pend = 0;
  int pend_cnt = 0;
  int exp_edges = 0;
  bit exp_valid = 0;
  bit exp_nosig = 0;
  bit exp_busy = 0;

  // Rising transitions in the sampled history that fall inside a window opened at 'start'.
  function automatic int count_window(input int start);
    int c;
    c = 0;
    for (int n = start - 1; n <= start + WIN - 2; n++) begin
      if (n >= 1 && n < HMAX && s_hist[n] && !s_hist[n-1]) c++;
    end
    return c;
  endfunction

  // Model: records what the sampler sees each edge and tracks windows from the enable history.
  always @(posedge clk) begin
    cyc++;
    if (cyc < HMAX) s_hist[cyc] = (rst === 1'b1) ? sig_in : 1'b0;
    if (rst !== 1'b1) begin
      in_win = 0; pend = 0;
      exp_edges = 0; exp_valid = 0; exp_nosig = 0; exp_busy = 0;
    end else begin
      exp_valid = pend;
      if (pend) begin
        exp_edges = pend_cnt;
        exp_nosig = (pend_cnt == 0);
      end
      pend = 0;
      if (!in_win) begin
        if (enable) begin
          in_win = 1;
          win_start = cyc;
        end
      end else if (cyc == win_start + WIN) begin
        pend_cnt = count_window(win_start);
        pend = 1;
        if (enable) win_start = cyc;
        else in_win = 0;
      end else if (!enable) begin
        in_win = 0;
      end
      exp_busy = in_win;
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_true(input string name, input bit cond, input int actual);
    checks++;
    if (!cond) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, outside allowed set (t=%0t)", name, actual, $time);
    end
  endtask

  // Compare process: every negedge, DUT outputs against the model (all zero while in reset).
  always @(negedge clk) begin
    if (cmp_en) begin
      if (rst !== 1'b1) begin
        check_output("rst_edges", int'(edges), 0);
        check_output("rst_valid", int'(valid), 0);
        check_output("rst_busy",  int'(busy),  0);
      end else begin
        check_output("m_edges", int'(edges), exp_edges);
        check_output("m_data",  int'(data_out), (exp_edges == 0) ? 0 : exp_edges - 1);
        check_output("m_valid", int'(valid), int'(exp_valid));
        check_output("m_nosig", int'(no_signal), int'(exp_nosig));
        check_output("m_busy",  int'(busy), int'(exp_busy));
      end
    end
  end

  // Advance one clock and drive the next sig_in sample according to the active pattern.
  task automatic apply_stimulus();
    @(negedge clk);
    phase++;
    case (mode)
      0: sig_in = 1'b0;
      1: sig_in = phase[0];
      2: sig_in = ((phase % period) >= (period / 2));
      default: begin
        acc = acc + 5'd6;
        sig_in = acc[WIDTH];
      end
    endcase
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 3 * WIN && !seen; i++) begin
      apply_stimulus();
      if (valid === 1'b1) seen = 1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: got no valid, expected valid within %0d cycles", name, 3 * WIN);
    end
  endtask

  initial begin
    int sum;
    bit vseen;
    rst = 1'b0; enable = 1'b0; sig_in = 1'b0;
    repeat (3) apply_stimulus();
    check_output("reset_edges", int'(edges), 0);
    check_output("reset_data", int'(data_out), 0);
    check_output("reset_nosig", int'(no_signal), 0);
    rst = 1'b1;
    cmp_en = 1;
    repeat (2) apply_stimulus();

    $display("[TB] silent input window");
    enable = 1'b1;
    repeat (WIN + 1) apply_stimulus();
    check_output("first_valid_early", int'(valid), 0);
    check_output("busy_during", int'(busy), 1);
    apply_stimulus();
    check_output("first_valid", int'(valid), 1);
    check_output("silent_edges", int'(edges), 0);
    check_output("silent_nosig", int'(no_signal), 1);
    repeat (WIN - 1) apply_stimulus();
    check_output("repeat_valid_early", int'(valid), 0);
    apply_stimulus();
    check_output("repeat_valid", int'(valid), 1);

    $display("[TB] clk/2 input");
    mode = 1;
    wait_valid("toggle_w1");
    wait_valid("toggle_w2");
    check_output("toggle_edges", int'(edges), 16);
    check_output("toggle_data", int'(data_out), 15);
    check_output("toggle_nosig", int'(no_signal), 0);

    $display("[TB] period 8 and 32");
    mode = 2; period = 8;
    wait_valid("p8_w1");
    wait_valid("p8_w2");
    check_output("p8_edges", int'(edges), 4);
    check_output("p8_data", int'(data_out), 3);
    period = 32;
    wait_valid("p32_w1");
    wait_valid("p32_w2");
    check_output("p32_edges", int'(edges), 1);
    check_output("p32_data", int'(data_out), 0);
    check_output("p32_nosig", int'(no_signal), 0);

    $display("[TB] generator loopback word 5");
    mode = 3;
    wait_valid("loop_w0");
    sum = 0;
    for (int w = 0; w < 4; w++) begin
      wait_valid("loop_w");
      check_true("loop_edges", (edges >= 5 && edges <= 7), int'(edges));
      check_true("loop_data", (data_out >= 4 && data_out <= 6), int'(data_out));
      sum += int'(data_out);
    end
    check_output("loop_avg", sum / 4, 5);

    $display("[TB] abort and restart");
    mode = 2; period = 8;
    wait_valid("ab_w1");
    wait_valid("ab_w2");
    check_output("ab_edges", int'(edges), 4);
    repeat (8) apply_stimulus();
    enable = 1'b0;
    apply_stimulus();
    check_output("ab_busy", int'(busy), 0);
    vseen = 0;
    repeat (40) begin
      apply_stimulus();
      if (valid === 1'b1) vseen = 1;
    end
    check_output("ab_no_valid", int'(vseen), 0);
    check_output("ab_edges_held", int'(edges), 4);
    enable = 1'b1;
    repeat (WIN + 1) apply_stimulus();
    check_output("ab_restart_early", int'(valid), 0);
    apply_stimulus();
    check_output("ab_restart_valid", int'(valid), 1);
    check_output("ab_restart_edges", int'(edges), 4);

    $display("[TB] reset mid-window");
    repeat (10) apply_stimulus();
    #2 rst = 1'b0;
    #1;
    check_output("async_edges", int'(edges), 0);
    check_output("async_data", int'(data_out), 0);
    check_output("async_valid", int'(valid), 0);
    check_output("async_nosig", int'(no_signal), 0);
    check_output("async_busy", int'(busy), 0);
    repeat (2) apply_stimulus();
    @(negedge clk);
    phase = 0; sig_in = 1'b0; rst = 1'b1;
    repeat (WIN + 1) apply_stimulus();
    check_output("rel_valid_early", int'(valid), 0);
    apply_stimulus();
    check_output("rel_valid", int'(valid), 1);
    check_output("rel_edges", int'(edges), 4);
    check_output("rel_data", int'(data_out), 3);

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
